// File: rtl/pixel_stream_fifo.sv
// First-word fall-through pixel FIFO with registered ready/valid/threshold flags.
// Define PIXEL_FIFO_STATS_EN to build the saturating underflow/overflow counters.
module pixel_stream_fifo #(
    parameter int unsigned DATA_W     = 25,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AFULL_LVL  = DEPTH - 4,
    parameter int unsigned AEMPTY_LVL = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [DATA_W-1:0]          in_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [15:0]                underflow_cnt_o,
    output logic [15:0]                overflow_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LVL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LVL);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          push, pop;

    assign push = in_valid_i && in_ready_q && !flush_i;
    assign pop  = out_valid_q && out_ready_i && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        // Flags are derived from the next level so they line up with level_o
        in_ready_d  = (level_d < DEPTH_L);
        out_valid_d = (level_d != '0);
        afull_d     = (level_d >= AFULL_L);
        aempty_d    = (level_d <= AEMPTY_L);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
    end

    assign out_data_o     = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid_o    = out_valid_q;
    assign in_ready_o     = in_ready_q;
    assign level_o        = level_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;

`ifdef PIXEL_FIFO_STATS_EN
    logic [15:0] underflow_cnt_q;
    logic [15:0] overflow_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            underflow_cnt_q <= '0;
            overflow_cnt_q  <= '0;
        end else begin
            if (out_ready_i && !out_valid_q && !flush_i && underflow_cnt_q != '1)
                underflow_cnt_q <= underflow_cnt_q + 16'd1;
            if (in_valid_i && !in_ready_q && !flush_i && overflow_cnt_q != '1)
                overflow_cnt_q <= overflow_cnt_q + 16'd1;
        end
    end

    assign underflow_cnt_o = underflow_cnt_q;
    assign overflow_cnt_o  = overflow_cnt_q;
`else
    assign underflow_cnt_o = '0;
    assign overflow_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Directed self-checking bench for pixel_stream_fifo at default parameters.
module tb_pixel_stream_fifo;

`ifdef PIXEL_FIFO_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b1;
    logic [24:0] in_data_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [24:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [4:0]  level_o;
    logic        almost_full_o;
    logic        almost_empty_o;
    logic [15:0] underflow_cnt_o;
    logic [15:0] overflow_cnt_o;

    int checks = 0;
    int errors = 0;

    pixel_stream_fifo #(.DATA_W(25), .DEPTH(16), .AFULL_LVL(12), .AEMPTY_LVL(4)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .in_data_i      (in_data_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .flush_i        (flush_i),
        .level_o        (level_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .underflow_cnt_o(underflow_cnt_o),
        .overflow_cnt_o (overflow_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_word(input logic [24:0] d);
        in_data_i  = d;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"},  32'(level_o), 0);
        check({tag, "_ovalid"}, 32'(out_valid_o), 0);
        check({tag, "_iready"}, 32'(in_ready_o), 0);
        check({tag, "_afull"},  32'(almost_full_o), 0);
        check({tag, "_aempty"}, 32'(almost_empty_o), 1);
        check({tag, "_uflow"},  32'(underflow_cnt_o), 0);
        check({tag, "_oflow"},  32'(overflow_cnt_o), 0);
    endtask

    initial begin
        int unsigned head;
        int unsigned next;

        #2 rstn_i = 1'b0;
        #1 check_reset_state("rst");
        step();
        step();
        check_reset_state("rst_hold");
        rstn_i = 1'b1;
        step();
        check("rel_iready", 32'(in_ready_o), 1);
        check("rel_ovalid", 32'(out_valid_o), 0);

        // Starved consumer on empty FIFO
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        out_ready_i = 1'b0;
        check("uflow5", 32'(underflow_cnt_o), 32'(STATS * 5));

        // Fill to full, checking thresholds and first-word latency
        for (int i = 1; i <= 16; i++) begin
            push_word(25'(i));
            check("fill_level", 32'(level_o), 32'(i));
            check("fill_afull", 32'(almost_full_o), (i >= 12) ? 32'd1 : 32'd0);
            check("fill_aempty", 32'(almost_empty_o), (i <= 4) ? 32'd1 : 32'd0);
            check("fill_head", 32'(out_data_o), 32'h1);
            check("fill_ovalid", 32'(out_valid_o), 1);
        end
        check("full_iready", 32'(in_ready_o), 0);

        push_word(25'h11);
        check("ovf_level", 32'(level_o), 16);
        check("ovf_cnt", 32'(overflow_cnt_o), 32'(STATS));
        step();
        check("hold_data", 32'(out_data_o), 32'h1);

        // Drain in order
        out_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("drain_data", 32'(out_data_o), 32'(i));
            step();
            check("drain_level", 32'(level_o), 32'(16 - i));
            check("drain_iready", 32'(in_ready_o), 1);
        end
        out_ready_i = 1'b0;
        check("drain_ovalid", 32'(out_valid_o), 0);
        check("drain_aempty", 32'(almost_empty_o), 1);
        check("drain_afull", 32'(almost_full_o), 0);
        check("drain_uflow", 32'(underflow_cnt_o), 32'(STATS * 5));
        check("drain_oflow", 32'(overflow_cnt_o), 32'(STATS));

        // Streaming at level 3 across several pointer wraps
        head = 32'h100;
        next = 32'h100;
        for (int i = 0; i < 3; i++) begin
            push_word(25'(next));
            next++;
        end
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data_i = 25'(next);
            check("stream_data", 32'(out_data_o), head);
            step();
            next++;
            head++;
            check("stream_level", 32'(level_o), 3);
        end
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stream_tail", 32'(out_data_o), head);
            step();
            head++;
        end
        out_ready_i = 1'b0;
        check("stream_empty", 32'(level_o), 0);

        // Pop of last word together with a push
        push_word(25'h200);
        in_data_i   = 25'h201;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check("pp_level", 32'(level_o), 1);
        check("pp_head", 32'(out_data_o), 32'h201);
        check("pp_ovalid", 32'(out_valid_o), 1);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("pp_drained", 32'(level_o), 0);

        // Flush at level 9 overriding a push and a pop
        for (int i = 0; i < 9; i++) push_word(25'(32'h300 + i));
        check("pre_flush_level", 32'(level_o), 9);
        flush_i     = 1'b1;
        in_data_i   = 25'h3FF;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        step();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check("flush_level", 32'(level_o), 0);
        check("flush_ovalid", 32'(out_valid_o), 0);
        check("flush_iready", 32'(in_ready_o), 1);
        push_word(25'h3AA);
        check("post_flush_head", 32'(out_data_o), 32'h3AA);
        check("post_flush_level", 32'(level_o), 1);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;

        // Asynchronous reset mid-stream at level 7
        for (int i = 0; i < 7; i++) push_word(25'(32'h400 + i));
        check("pre_rst_level", 32'(level_o), 7);
        #2 rstn_i = 1'b0;
        #1 check_reset_state("arst");
        step();
        rstn_i = 1'b1;
        step();
        check("arst_rel_ovalid", 32'(out_valid_o), 0);
        check("arst_rel_iready", 32'(in_ready_o), 1);
        check("arst_rel_level", 32'(level_o), 0);
        push_word(25'h4BB);
        check("arst_new_head", 32'(out_data_o), 32'h4BB);
        check("arst_new_level", 32'(level_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_stream_fifo.md
PIXEL_STREAM_FIFO -- requirements
Module: pixel_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 25, meaning payload width (24-bit RGB plus 1 flag bit).
REQ-002 SHALL have parameter DEPTH, default 16, meaning entry count; SHALL be a power of two, at least 4.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-4, meaning the almost-full threshold.
REQ-004 SHALL have parameter AEMPTY_LVL, default 4, meaning the almost-empty threshold.
REQ-005 clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-006 rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 in_data_i  in  DATA_W  write payload.
REQ-008 in_valid_i  in  1  write request.
REQ-009 in_ready_o  out  1  FIFO can accept a word.
REQ-010 out_data_o  out  DATA_W  head-of-FIFO payload.
REQ-011 out_valid_o  out  1  head word is valid.
REQ-012 out_ready_i  in  1  consumer takes the head word.
REQ-013 flush_i  in  1  synchronous discard of all contents.
REQ-014 level_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-015 almost_full_o  out  1  level_o >= AFULL_LVL.
REQ-016 almost_empty_o  out  1  level_o <= AEMPTY_LVL.
REQ-017 underflow_cnt_o  out  16  count of starved consumer cycles (see Configuration).
REQ-018 overflow_cnt_o  out  16  count of rejected write cycles (see Configuration).

Function
REQ-019 Push SHALL occur on a cycle with in_valid_i && in_ready_o && !flush_i.
REQ-020 Pop SHALL occur on a cycle with out_valid_o && out_ready_i && !flush_i.
REQ-021 in_ready_o SHALL equal (level_o < DEPTH), registered; a pop in the same cycle SHALL NOT raise in_ready_o when full.
REQ-022 out_valid_o SHALL equal (level_o != 0); out_data_o SHALL show the oldest word (first-word fall-through).
REQ-023 Storage SHALL be an array of DEPTH words, with write and read pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
REQ-024 Pointers SHALL wrap modulo DEPTH with no gap or duplicate across the wrap.
REQ-025 Latency from a push into an empty FIFO to out_valid_o=1 SHALL be exactly 1 cycle.
REQ-026 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve order.
REQ-027 A pop on the last word and a push in the same cycle SHALL give level 1, with the new word at the head next cycle.
REQ-028 flush_i SHALL set both pointers and level to 0 on the next cycle and SHALL override any push or pop in that cycle.
REQ-029 almost_full_o and almost_empty_o SHALL be registered; each SHALL be consistent with level_o in the same cycle.
REQ-030 out_data_o SHALL hold its value while out_valid_o=1 and out_ready_i=0.

Reset
REQ-031 When rstn_i goes low, the block SHALL immediately clear pointers, level_o=0, out_valid_o=0, in_ready_o=0, almost_full_o=0, almost_empty_o=1 and both counters to 0.
REQ-032 in_ready_o SHALL rise on the first clock edge after rstn_i deasserts.
REQ-033 Storage contents SHALL NOT be reset; out_data_o is don't-care while out_valid_o=0.
REQ-034 Reset mid-stream SHALL discard all words; no stale word SHALL appear after release.

Configuration
REQ-035 With macro PIXEL_FIFO_STATS_EN defined, underflow_cnt_o SHALL increment on each cycle with out_ready_i && !out_valid_o && !flush_i.
REQ-036 With PIXEL_FIFO_STATS_EN defined, overflow_cnt_o SHALL increment on each cycle with in_valid_i && !in_ready_o && !flush_i.
REQ-037 With PIXEL_FIFO_STATS_EN defined, both counters SHALL saturate at 16'hFFFF and clear only on reset.
REQ-038 Without PIXEL_FIFO_STATS_EN, both counters SHALL be tied to 16'h0000 and no counter registers SHALL be synthesised.

Verification
REQ-039 Push 16 words 0x000001..0x000010 with DEPTH=16 and no pops -> level_o=16, in_ready_o=0, almost_full_o=1; a 17th write is rejected, overflow_cnt_o=1 (STATS_EN).
REQ-040 Drain the full FIFO -> words 0x000001..0x000010 in order; then out_valid_o=0, almost_empty_o=1.
REQ-041 Run continuous push and pop for 100 cycles from level 3 -> level_o stays 3, with no data loss across 6 pointer wraps.
REQ-042 Hold out_ready_i=1 on an empty FIFO for 5 cycles -> underflow_cnt_o=5 (STATS_EN) or 0 (no macro).
REQ-043 Assert flush_i at level 9 together with a push -> the next cycle shows level_o=0, out_valid_o=0, in_ready_o=1.
REQ-044 Pulse rstn_i low asynchronously at level 7 -> outputs take their REQ-031 values before the next edge; after release, out_valid_o=0.
